rv_alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational RV32I ALU.
- Covers the full RV32I integer op set at configurable XLEN, with operand-B/immediate selection.
- Shifts use an iterative shifter: SHIFT_STEP bit positions per cycle, trading latency for area.
- Sits between decode/operand-fetch and writeback; valid/ready on both sides lets the core stall around multi-cycle ops.

---
 rtl/rv_alu_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_rv_alu_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_seq.sv
// rv_alu_seq: handshaked RV32I-style ALU with an iterative shifter.
// Single-cycle ops finish one cycle after accept. Shifts step SHIFT_STEP
// bit positions per cycle. Define RV_ALU_MUL_EN to add an iterative
// shift-add MUL on op 10; without it, op 10 is reported as illegal.
module rv_alu_seq #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1,
   localparam int SHW       = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [XLEN-1:0] imm,
   input  logic            b_sel,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            err
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef RV_ALU_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd10;
`endif

   // Shift counter is one bit wider so SHIFT_STEP == XLEN is representable.
   localparam logic [SHW:0] STEP_C = (SHW+1)'(SHIFT_STEP);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
`ifdef RV_ALU_MUL_EN
      S_MUL,
`endif
      S_DONE
   } state_t;

   state_t          state_reg, state_next;
   logic [3:0]      op_reg;
   logic [XLEN-1:0] work_reg;
   logic [SHW:0]    cnt_reg;
   logic [XLEN-1:0] result_reg;
   logic            zero_reg;
   logic            err_reg;
`ifdef RV_ALU_MUL_EN
   logic [XLEN-1:0] acc_reg, mcand_reg, mplier_reg;
   logic [XLEN-1:0] acc_sum;
   logic            mul_last;
`endif

   logic [XLEN-1:0] opb;
   logic [SHW:0]    shamt_in;
   logic            is_shift;
   logic            illegal;
   logic [XLEN-1:0] single_res;
   logic [SHW:0]    step;
   logic [XLEN-1:0] shifted;
   logic            shift_last;
   logic            accept;
   logic            load_result;
   logic [XLEN-1:0] load_val;
   logic            load_err;

   // Operand selection and the single-cycle result computed from live inputs.
   always_comb begin
      opb        = b_sel ? imm : b;
      shamt_in   = {1'b0, opb[SHW-1:0]};
      is_shift   = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
      illegal    = 1'b0;
      single_res = '0;
      case (op)
         OP_ADD:  single_res = a + opb;
         OP_SUB:  single_res = a - opb;
         OP_AND:  single_res = a & opb;
         OP_OR:   single_res = a | opb;
         OP_XOR:  single_res = a ^ opb;
         OP_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(opb))};
         OP_SLTU: single_res = {{(XLEN-1){1'b0}}, (a < opb)};
         // Only reached when shamt is zero: the result is a unchanged.
         OP_SLL, OP_SRL, OP_SRA: single_res = a;
`ifdef RV_ALU_MUL_EN
         // Only reached when the multiplier is zero.
         OP_MUL:  single_res = '0;
`endif
         default: illegal = 1'b1;
      endcase
   end

   // One shifter iteration: shift by min(SHIFT_STEP, remaining).
   always_comb begin
      step       = (cnt_reg < STEP_C) ? cnt_reg : STEP_C;
      shift_last = (cnt_reg <= STEP_C);
      case (op_reg)
         OP_SLL:  shifted = work_reg << step;
         OP_SRA:  shifted = $signed(work_reg) >>> step;
         default: shifted = work_reg >> step;
      endcase
   end

`ifdef RV_ALU_MUL_EN
   // One shift-add multiplier iteration; stop once no multiplier bits remain.
   always_comb begin
      acc_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
      mul_last = ((mplier_reg >> 1) == '0);
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state, handshake outputs and result-load strobe.
   always_comb begin
      state_next  = state_reg;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      accept      = 1'b0;
      load_result = 1'b0;
      load_val    = '0;
      load_err    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               if (is_shift && (shamt_in != '0)) begin
                  state_next = S_SHIFT;
`ifdef RV_ALU_MUL_EN
               end else if ((op == OP_MUL) && (opb != '0)) begin
                  state_next = S_MUL;
`endif
               end else begin
                  state_next  = S_DONE;
                  load_result = 1'b1;
                  load_val    = single_res;
                  load_err    = illegal;
               end
            end
         end
         S_SHIFT: begin
            if (shift_last) begin
               state_next  = S_DONE;
               load_result = 1'b1;
               load_val    = shifted;
            end
         end
`ifdef RV_ALU_MUL_EN
         S_MUL: begin
            if (mul_last) begin
               state_next  = S_DONE;
               load_result = 1'b1;
               load_val    = acc_sum;
            end
         end
`endif
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: latch operands at accept, iterate, and capture the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg     <= '0;
         work_reg   <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
         zero_reg   <= 1'b1;
         err_reg    <= 1'b0;
`ifdef RV_ALU_MUL_EN
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
`endif
      end else begin
         if (accept) begin
            op_reg   <= op;
            work_reg <= a;
            cnt_reg  <= shamt_in;
`ifdef RV_ALU_MUL_EN
            acc_reg    <= '0;
            mcand_reg  <= a;
            mplier_reg <= opb;
`endif
         end
         if (state_reg == S_SHIFT) begin
            work_reg <= shifted;
            cnt_reg  <= cnt_reg - step;
         end
`ifdef RV_ALU_MUL_EN
         if (state_reg == S_MUL) begin
            acc_reg    <= acc_sum;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
         end
`endif
         if (load_result) begin
            result_reg <= load_val;
            zero_reg   <= (load_val == '0);
            err_reg    <= load_err;
         end
      end
   end

   assign result = result_reg;
   assign zero   = zero_reg;
   assign err    = err_reg;

endmodule

// File: tb/tb_rv_alu_seq.sv
// tb_rv_alu_seq: table-driven and random checks of rv_alu_seq (XLEN=32,
// SHIFT_STEP=1), plus a SHIFT_STEP=4 instance for step-size latency.
// Follows RV_ALU_MUL_EN for the op 10 expectation.
module tb_rv_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [31:0] a, b, imm;
   logic        b_sel;
   logic [31:0] result;
   logic        zero, err;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [31:0] result4;
   logic        zero4, err4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_alu_seq #(.XLEN(32), .SHIFT_STEP(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .imm(imm), .b_sel(b_sel),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .err(err)
   );

   rv_alu_seq #(.XLEN(32), .SHIFT_STEP(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .op(op), .a(a), .b(b), .imm(imm), .b_sel(b_sel),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .zero(zero4), .err(err4)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, imm;
      logic        b_sel;
      logic [31:0] res;
      logic        zero, err;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        zero, err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model for random vectors.
   function automatic logic [31:0] model_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      case (o)
         4'd0: r = x + y;
         4'd1: r = x - y;
         4'd2: r = x & y;
         4'd3: r = x | y;
         4'd4: r = x ^ y;
         4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'd6: r = (x < y) ? 32'd1 : 32'd0;
         4'd7: r = x << y[4:0];
         4'd8: r = x >> y[4:0];
         4'd9: r = $signed(x) >>> y[4:0];
`ifdef RV_ALU_MUL_EN
         4'd10: r = x * y;
`endif
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [3:0] o, input logic [31:0] y);
      if (o == 4'd7 || o == 4'd8 || o == 4'd9) return 1 + int'(y[4:0]);
      return 1;
   endfunction

   // Drive one op, push its expectation, then wait for and score the result.
   task automatic run_op(input string name, input logic [3:0] op_i, input logic [31:0] a_i,
                         input logic [31:0] b_i, input logic [31:0] imm_i, input logic bsel_i,
                         input logic [31:0] er, input logic ez, input logic ee, input int el);
      exp_t e;
      int   lat;
      e.res = er; e.zero = ez; e.err = ee; e.lat = el;
      sb.push_back(e);
      @(negedge clk);
      op = op_i; a = a_i; b = b_i; imm = imm_i; b_sel = bsel_i; in_valid = 1'b1;
      chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      // Scramble inputs after accept: the DUT must have latched them.
      in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; imm = $urandom; b_sel = ~b_sel;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      e = sb.pop_front();
      chk({name, ".latency"}, 64'(lat), 64'(e.lat));
      chk({name, ".result"}, 64'(result), 64'(e.res));
      chk({name, ".zero"}, 64'(zero), 64'(e.zero));
      chk({name, ".err"}, 64'(err), 64'(e.err));
      $display("op %s code=%0d a=%h b=%h imm=%h b_sel=%0d -> result=%h zero=%0d err=%0d lat=%0d",
               name, op_i, a_i, b_i, imm_i, bsel_i, result, zero, err, lat);
   endtask

   initial begin
      int lat;
      logic [31:0] ra, rb, ri, opb_r;
      logic [3:0]  ro;
      logic        rs;

      rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1; out_ready4 = 1'b1;
      op = '0; a = '0; b = '0; imm = '0; b_sel = 1'b0;

      // Fixed vectors: op, a, b, imm, b_sel, result, zero, err, latency.
      vecs[0]  = '{4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 32'd12, 1'b0, 1'b0, 1};
      vecs[1]  = '{4'd0, 32'd5, 32'd7, 32'hFFFFFFFF, 1'b1, 32'd4, 1'b0, 1'b0, 1};
      vecs[2]  = '{4'd1, 32'd3, 32'd3, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1};
      vecs[3]  = '{4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
      vecs[4]  = '{4'd5, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 1};
      vecs[5]  = '{4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1};
      vecs[6]  = '{4'd9, 32'h80000000, 32'h25, 32'd0, 1'b0, 32'hFC000000, 1'b0, 1'b0, 6};
      vecs[7]  = '{4'd7, 32'h1234, 32'h20, 32'd0, 1'b0, 32'h1234, 1'b0, 1'b0, 1};
      vecs[8]  = '{4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 32'h00F000F0, 1'b0, 1'b0, 1};
      vecs[9]  = '{4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0, 1};
      vecs[10] = '{4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 32'hFF00FF00, 1'b0, 1'b0, 1};
      vecs[11] = '{4'd8, 32'h80000000, 32'd31, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 32};
      vecs[12] = '{4'd12, 32'd9, 32'd9, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1};
`ifdef RV_ALU_MUL_EN
      vecs[13] = '{4'd10, 32'hFFFF, 32'h10001, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 18};
`else
      vecs[13] = '{4'd10, 32'hFFFF, 32'h10001, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1};
`endif
      vecs[14] = '{4'd7, 32'd3, 32'hFF, 32'd4, 1'b1, 32'h30, 1'b0, 1'b0, 5};
      vecs[15] = '{4'd5, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1};

      // Reset state.
      #1;
      chk("reset.in_ready", 64'(in_ready), 64'd1);
      chk("reset.out_valid", 64'(out_valid), 64'd0);
      chk("reset.result", 64'(result), 64'd0);
      chk("reset.zero", 64'(zero), 64'd1);
      chk("reset.err", 64'(err), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].b_sel,
                vecs[i].res, vecs[i].zero, vecs[i].err, vecs[i].lat);

      // Random legal ops scored against the model.
      for (int i = 0; i < 20; i++) begin
         ro = 4'($urandom_range(0, 9)); ra = $urandom; rb = $urandom; ri = $urandom; rs = 1'($urandom);
         opb_r = rs ? ri : rb;
         run_op($sformatf("rnd%0d", i), ro, ra, rb, ri, rs, model_res(ro, ra, opb_r),
                model_res(ro, ra, opb_r) == 32'd0, 1'b0, model_lat(ro, opb_r));
      end

      // Backpressure: result held, no accept while out_ready is low.
      @(negedge clk);
      out_ready = 1'b0; op = 4'd0; a = 32'd9; b = 32'd1; b_sel = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
      chk("bp.latency", 64'(lat), 64'd1);
      for (int k = 0; k < 3; k++) begin
         in_valid = ~in_valid; op = 4'(k + 1); a = $urandom;
         @(negedge clk);
         chk($sformatf("bp%0d.out_valid", k), 64'(out_valid), 64'd1);
         chk($sformatf("bp%0d.result", k), 64'(result), 64'd10);
         chk($sformatf("bp%0d.in_ready", k), 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bp.release.out_valid", 64'(out_valid), 64'd0);
      chk("bp.release.in_ready", 64'(in_ready), 64'd1);
      chk("bp.release.result_held", 64'(result), 64'd10);
      $display("op backpressure ADD 9+1 held result=%h", result);

      // Asynchronous reset in the middle of SRL shamt=20.
      op = 4'd8; a = 32'hFFFFFFFF; b = 32'd20; b_sel = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_mid.busy_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      #1;
      chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
      chk("rst_mid.result", 64'(result), 64'd0);
      chk("rst_mid.zero", 64'(zero), 64'd1);
      chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      chk("rst_mid.no_result", 64'(out_valid), 64'd0);
      $display("op reset-abort SRL shamt=20 out_valid=%0d result=%h", out_valid, result);
      run_op("post_rst_add", 4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 32'd2, 1'b0, 1'b0, 1);

      // SHIFT_STEP=4 instance: SRA shamt=5 and SRL shamt=31 (partial last step).
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         op = (t == 0) ? 4'd9 : 4'd8;
         a = (t == 0) ? 32'h80000000 : 32'hFFFFFFFF;
         b = (t == 0) ? 32'h25 : 32'd31;
         b_sel = 1'b0; in_valid4 = 1'b1;
         chk($sformatf("step4_%0d.in_ready", t), 64'(in_ready4), 64'd1);
         @(negedge clk);
         in_valid4 = 1'b0; a = $urandom; b = $urandom;
         lat = 1;
         while (!out_valid4 && lat < 50) begin @(negedge clk); lat++; end
         chk($sformatf("step4_%0d.latency", t), 64'(lat), (t == 0) ? 64'd3 : 64'd9);
         chk($sformatf("step4_%0d.result", t), 64'(result4), (t == 0) ? 64'hFC000000 : 64'd1);
         chk($sformatf("step4_%0d.err", t), 64'(err4), 64'd0);
         $display("op step4 shift %0d -> result=%h lat=%0d", t, result4, lat);
      end
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
